aqed_lb_resp_checker: RTL and testbench
=======================================

Name: aqed_lb_resp_checker

Overview:
- Output-side (receiver) half of the A-QED harness for the memory-core line buffer.
- Watches the accelerator input stream (wen/data_in) and output stream (valid_out/data_out).
- Maps each output to its input by FIFO position: output k corresponds to input k.
- Captures the outputs belonging to the marked original and duplicate inputs, then raises qed_done/qed_check and a response-bound violation flag for formal properties and simulation benches.

Parameters:
- DW, 16, data width of input and output streams
- CW, 17, width of input/output position counters
- BOUND_MUL, 4, response bound multiplier: the original is late once BOUND_MUL*depth inputs have been accepted after it

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- clk_en  in  1  state-update enable; when low, all registers hold
- in_valid  in  1  input accepted by the line buffer this cycle (wen)
- in_data  in  DW  input data
- orig_mark  in  1  qualifies the current in_valid beat as the original
- dup_mark  in  1  qualifies the current in_valid beat as the duplicate
- out_valid  in  1  line buffer output valid
- out_data  in  DW  line buffer output data
- depth  in  16  configured line-buffer depth, static after reset
- orig_issued  out  1  sticky: original accepted
- dup_issued  out  1  sticky: duplicate accepted
- orig_done  out  1  sticky: original's output captured
- qed_done  out  1  sticky: both outputs captured
- qed_check  out  1  orig_out==dup_out; meaningful only while qed_done=1
- resp_timeout  out  1  sticky response-bound violation
- in_cnt  out  CW  inputs accepted so far
- out_cnt  out  CW  outputs seen so far

Behaviour:
- Reset:
  - Synchronous, active-high; overrides clk_en.
  - All outputs are 0; internal state is IDLE.
  - Captured indices and data are 0.
- Gating: every register update requires clk_en=1. Inputs are ignored in cycles with clk_en=0.
- Counters:
  - in_cnt increments on in_valid; out_cnt increments on out_valid.
  - Both saturate at 2^CW-1 and never wrap.
- State machine: IDLE -> ORIG -> DUP -> DONE.
  - IDLE: when in_valid&orig_mark and in_cnt not saturated:
    - orig_idx<=in_cnt, orig_in<=in_data, orig_issued<=1.
    - Go to ORIG.
  - ORIG: when in_valid&dup_mark and in_data==orig_in:
    - dup_idx<=in_cnt, dup_issued<=1.
    - Go to DUP.
    - If in_data!=orig_in, the mark is ignored and the state stays ORIG.
  - DUP: when both outputs are captured:
    - qed_done<=1, qed_check<=(orig_out==dup_out).
    - Go to DONE.
  - DONE: terminal until reset. All marks are ignored.
- Output capture:
  - On out_valid with out_cnt==orig_idx, after the original is issued: orig_out<=out_data, orig_done<=1.
  - Same rule for dup_idx, once the duplicate is issued.
  - Each capture happens once only.
  - Same-cycle case: if orig_mark and out_valid with out_cnt==in_cnt occur in the same cycle, the output is captured that cycle, using the live index. The same applies to dup_mark.
- qed_done latency:
  - qed_done rises exactly 1 cycle after the later of the two captures.
  - If both captures occur in the DUP-entry cycle, qed_done rises on the next cycle.
- Response bound:
  - after_cnt (CW, saturating) counts in_valid beats after the original beat.
  - resp_timeout<=1 when orig_issued && !orig_done && after_cnt>=BOUND_MUL*depth.
  - Multiply is done at CW+2 bits; no truncation.
- Marks:
  - Marks without in_valid are ignored.
  - orig_mark&dup_mark together in IDLE: treated as the original only.
  - dup_mark in IDLE: ignored.
- Reset mid-operation clears all sticky flags and counters. In-flight outputs from before reset are counted from zero again.

Decomposition:
- Package aqed_lb_pkg:
  - state enum (IDLE, ORIG, DUP, DONE)
  - DW and CW localparams
  - BOUND_MUL default
- One natural sub-module: aqed_sat_counter (parameterized width, enable, synchronous clear, saturating). Instantiated for in_cnt, out_cnt and after_cnt.

Test Plan:
- Matching pair:
  - depth=2, inputs 0x10,0x11,0x12,0x13,0x11; orig at beat 1, dup at beat 4 (data 0x11).
  - Outputs echo inputs in order.
  - Required: qed_done=1 and qed_check=1 one cycle after out #4.
- Corrupted output: same stimulus but out #4=0x99 -> qed_done=1, qed_check=0.
- Data-mismatched dup: dup_mark on beat data 0x12 while orig_in=0x11 -> state stays ORIG, dup_issued=0, qed_done never rises.
- Response bound:
  - depth=3, orig at beat 0, then 12 more inputs, no out_valid.
  - Required: resp_timeout=1 the cycle after the 12th post-orig beat; 0 after only 11.
- clk_en gating: clk_en=0 while in_valid=1 for 5 cycles -> in_cnt unchanged; on clk_en=1 it resumes counting.
- Reset mid-operation: reset in the DUP state -> next cycle all outputs are 0 and state is IDLE; a new orig/dup pair then completes with qed_check=1.

Source files
------------

// File: rtl/aqed_lb_pkg.sv
// Shared types and defaults for the A-QED line-buffer response checker.
// Stream and counter widths, the response-bound multiplier and the FSM state type.
package aqed_lb_pkg;

  localparam int DW        = 16;
  localparam int CW        = 17;
  localparam int BOUND_MUL = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ORIG = 2'd1,
    DUP  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/aqed_lb_resp_checker_if.sv
// Line-buffer input/output stream as seen by the A-QED harness.
// The master drives the accepted inputs, the marks and the buffer outputs; the checker only observes.
interface aqed_lb_resp_checker_if #(
  parameter int DW = aqed_lb_pkg::DW
) ();

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          orig_mark;
  logic          dup_mark;
  logic          out_valid;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output orig_mark,
    output dup_mark,
    output out_valid,
    output out_data
  );

  modport slave (
    input in_valid,
    input in_data,
    input orig_mark,
    input dup_mark,
    input out_valid,
    input out_data
  );

endinterface

// File: rtl/aqed_lb_resp_checker_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
// Synchronous clear; the caller folds any clock enable into en and clr.
module aqed_sat_counter #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && !(&cnt)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/aqed_lb_resp_checker.sv
// Receiver half of the A-QED harness: pairs line-buffer outputs with inputs by FIFO position,
// captures the outputs of the marked original/duplicate and reports consistency and response bound.
//
// state | meaning
// IDLE  | waiting for the original beat
// ORIG  | original accepted, waiting for a duplicate carrying identical data
// DUP   | both issued, waiting for both outputs to be captured
// DONE  | verdict latched, terminal until reset
module aqed_lb_resp_checker #(
  parameter int DW        = aqed_lb_pkg::DW,
  parameter int CW        = aqed_lb_pkg::CW,
  parameter int BOUND_MUL = aqed_lb_pkg::BOUND_MUL
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  aqed_lb_resp_checker_if.slave   bus,
  input  logic [15:0]             depth,
  output logic                    orig_issued,
  output logic                    dup_issued,
  output logic                    orig_done,
  output logic                    qed_done,
  output logic                    qed_check,
  output logic                    resp_timeout,
  output logic [CW-1:0]           in_cnt,
  output logic [CW-1:0]           out_cnt
);

  import aqed_lb_pkg::*;

  localparam int BW = CW + 2;

  state_t        state;
  logic [CW-1:0] orig_idx;
  logic [CW-1:0] dup_idx;
  logic [DW-1:0] orig_in;
  logic [DW-1:0] orig_out;
  logic [DW-1:0] dup_out;
  logic          dup_done;
  logic [CW-1:0] after_cnt;

  logic          orig_accept;
  logic          dup_accept;
  logic          orig_hit;
  logic          dup_hit;
  logic          orig_done_nxt;
  logic          dup_done_nxt;
  logic [DW-1:0] orig_out_nxt;
  logic [DW-1:0] dup_out_nxt;
  logic          after_step;
  logic [BW-1:0] after_sum;
  logic [BW-1:0] bound;
  logic          timeout_now;

  aqed_sat_counter #(.W(CW)) u_in_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (clk_en && bus.in_valid),
    .clr   (1'b0),
    .cnt   (in_cnt)
  );

  aqed_sat_counter #(.W(CW)) u_out_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (clk_en && bus.out_valid),
    .clr   (1'b0),
    .cnt   (out_cnt)
  );

  // Counts only beats strictly after the original; restarts when an original is taken.
  aqed_sat_counter #(.W(CW)) u_after_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (clk_en && bus.in_valid && orig_issued),
    .clr   (clk_en && orig_accept),
    .cnt   (after_cnt)
  );

  always_comb begin
    orig_accept = bus.in_valid && bus.orig_mark && (state == IDLE) && !(&in_cnt);
    dup_accept  = bus.in_valid && bus.dup_mark && (state == ORIG) && (bus.in_data == orig_in);

    // A beat whose output appears in its own acceptance cycle is matched against the live in_cnt.
    orig_hit = bus.out_valid && !orig_done &&
               ((orig_issued && (out_cnt == orig_idx)) || (orig_accept && (out_cnt == in_cnt)));
    dup_hit  = bus.out_valid && !dup_done &&
               ((dup_issued && (out_cnt == dup_idx)) || (dup_accept && (out_cnt == in_cnt)));

    orig_done_nxt = orig_done || orig_hit;
    dup_done_nxt  = dup_done || dup_hit;
    orig_out_nxt  = orig_hit ? bus.out_data : orig_out;
    dup_out_nxt   = dup_hit ? bus.out_data : dup_out;

    // Look one beat ahead so the flag lands the cycle after the bound-reaching beat.
    after_step  = bus.in_valid && orig_issued && !(&after_cnt);
    after_sum   = BW'(after_cnt) + BW'(after_step);
    bound       = BW'(BOUND_MUL) * BW'(depth);
    timeout_now = orig_issued && !orig_done_nxt && (after_sum >= bound);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      orig_idx     <= '0;
      dup_idx      <= '0;
      orig_in      <= '0;
      orig_out     <= '0;
      dup_out      <= '0;
      dup_done     <= 1'b0;
      orig_issued  <= 1'b0;
      dup_issued   <= 1'b0;
      orig_done    <= 1'b0;
      qed_done     <= 1'b0;
      qed_check    <= 1'b0;
      resp_timeout <= 1'b0;
    end else if (clk_en) begin
      orig_out     <= orig_out_nxt;
      dup_out      <= dup_out_nxt;
      orig_done    <= orig_done_nxt;
      dup_done     <= dup_done_nxt;
      resp_timeout <= resp_timeout || timeout_now;

      case (state)
        IDLE: begin
          if (orig_accept) begin
            orig_idx    <= in_cnt;
            orig_in     <= bus.in_data;
            orig_issued <= 1'b1;
            state       <= ORIG;
          end
        end
        ORIG: begin
          if (dup_accept) begin
            dup_idx    <= in_cnt;
            dup_issued <= 1'b1;
            state      <= DUP;
          end
        end
        DUP: begin
          if (orig_done_nxt && dup_done_nxt) begin
            qed_done  <= 1'b1;
            qed_check <= (orig_out_nxt == dup_out_nxt);
            state     <= DONE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aqed_lb_resp_checker.sv
// Self-checking bench for aqed_lb_resp_checker: scripted input/output streams with a
// scoreboard of expected qed_check verdicts, plus response-bound, gating and reset scenarios.
module tb_aqed_lb_resp_checker;
  import aqed_lb_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic [15:0]   depth;
  logic          orig_issued;
  logic          dup_issued;
  logic          orig_done;
  logic          qed_done;
  logic          qed_check;
  logic          resp_timeout;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;

  int checks = 0;
  int errors = 0;

  bit            exp_q[$];
  logic [DW-1:0] stim[$];

  aqed_lb_resp_checker_if #(.DW(DW)) bus ();

  aqed_lb_resp_checker #(.DW(DW), .CW(CW), .BOUND_MUL(BOUND_MUL)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .bus          (bus),
    .depth        (depth),
    .orig_issued  (orig_issued),
    .dup_issued   (dup_issued),
    .orig_done    (orig_done),
    .qed_done     (qed_done),
    .qed_check    (qed_check),
    .resp_timeout (resp_timeout),
    .in_cnt       (in_cnt),
    .out_cnt      (out_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.orig_mark = 1'b0;
    bus.dup_mark  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    logic [5:0] flags;
    flags = {orig_issued, dup_issued, orig_done, qed_done, qed_check, resp_timeout};
    checks++;
    if (flags !== 6'b0) begin
      errors++;
      $display("FAIL %s flags: got %b expected 000000", name, flags);
    end
    checks++;
    if (in_cnt !== '0) begin
      errors++;
      $display("FAIL %s in_cnt: got %0d expected 0", name, in_cnt);
    end
    checks++;
    if (out_cnt !== '0) begin
      errors++;
      $display("FAIL %s out_cnt: got %0d expected 0", name, out_cnt);
    end
  endtask

  // Drives stim[] as the input stream and echoes it (optionally corrupted) on the output
  // `lag` cycles later; the verdict is predicted from the bench's own copy of the outputs.
  task automatic run_stream(input string name, input int orig_pos, input int dup_pos,
                            input int lag, input int corrupt_pos,
                            input logic [DW-1:0] corrupt_val, input bit dup_ok);
    int            n;
    int            done_cyc;
    int            exp_out;
    bit            popped;
    bit            exp_done;
    bit            exp_chk;
    logic [DW-1:0] outs[$];
    n = stim.size();
    outs = {};
    for (int k = 0; k < n; k++) outs.push_back((k == corrupt_pos) ? corrupt_val : stim[k]);
    done_cyc = orig_pos + lag;
    if (dup_pos + lag > done_cyc) done_cyc = dup_pos + lag;
    if (dup_pos + 1 > done_cyc) done_cyc = dup_pos + 1;
    if (dup_ok) exp_q.push_back(outs[orig_pos] == outs[dup_pos]);
    popped = 1'b0;
    for (int t = 0; t < n + lag + 2; t++) begin
      bus.in_valid  = (t < n);
      bus.in_data   = (t < n) ? stim[t] : '0;
      bus.orig_mark = (t == orig_pos);
      bus.dup_mark  = (t == dup_pos);
      bus.out_valid = (t >= lag) && (t - lag < n);
      bus.out_data  = '0;
      if (bus.out_valid) bus.out_data = outs[t - lag];
      tick();
      exp_done = dup_ok && (t >= done_cyc);
      checks++;
      if (qed_done !== exp_done) begin
        errors++;
        $display("FAIL %s qed_done t=%0d: got %b expected %b", name, t, qed_done, exp_done);
      end
      checks++;
      if (in_cnt !== CW'((t < n) ? t + 1 : n)) begin
        errors++;
        $display("FAIL %s in_cnt t=%0d: got %0d expected %0d", name, t, in_cnt, (t < n) ? t + 1 : n);
      end
      exp_out = t - lag + 1;
      if (exp_out < 0) exp_out = 0;
      if (exp_out > n) exp_out = n;
      checks++;
      if (out_cnt !== CW'(exp_out)) begin
        errors++;
        $display("FAIL %s out_cnt t=%0d: got %0d expected %0d", name, t, out_cnt, exp_out);
      end
      if (qed_done === 1'b1 && !popped && exp_q.size() > 0) begin
        exp_chk = exp_q.pop_front();
        popped  = 1'b1;
        checks++;
        if (qed_check !== exp_chk) begin
          errors++;
          $display("FAIL %s qed_check: got %b expected %b", name, qed_check, exp_chk);
        end
      end
    end
    idle_inputs();
    checks++;
    if (orig_done !== 1'b1) begin
      errors++;
      $display("FAIL %s orig_done: got %b expected 1", name, orig_done);
    end
    checks++;
    if (dup_issued !== dup_ok) begin
      errors++;
      $display("FAIL %s dup_issued: got %b expected %b", name, dup_issued, dup_ok);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s scoreboard: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    clk_en = 1'b0;
    depth  = 16'd2;
    do_reset();
    check_all_zero("reset");
  endtask

  task automatic test_match();
    clk_en = 1'b1;
    depth  = 16'd2;
    do_reset();
    stim = '{16'h10, 16'h11, 16'h12, 16'h13, 16'h11};
    run_stream("match", 1, 4, 2, -1, 16'h0, 1'b1);
  endtask

  task automatic test_corrupt();
    do_reset();
    stim = '{16'h10, 16'h11, 16'h12, 16'h13, 16'h11};
    run_stream("corrupt", 1, 4, 2, 4, 16'h99, 1'b1);
  endtask

  task automatic test_dup_mismatch();
    do_reset();
    stim = '{16'h10, 16'h11, 16'h12, 16'h13};
    run_stream("dup_mismatch", 1, 2, 1, -1, 16'h0, 1'b0);
  endtask

  // Outputs in the same cycle as their marks, then marks in DONE must change nothing.
  task automatic test_same_cycle();
    do_reset();
    stim = '{16'h05, 16'h06, 16'h05, 16'h07};
    run_stream("same_cycle", 0, 2, 0, -1, 16'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'h05;
      bus.orig_mark = 1'b1;
      bus.dup_mark  = 1'b1;
      tick();
    end
    idle_inputs();
    checks++;
    if ({qed_done, qed_check} !== 2'b11) begin
      errors++;
      $display("FAIL done_hold: got %b expected 11", {qed_done, qed_check});
    end
    checks++;
    if (in_cnt !== CW'(6)) begin
      errors++;
      $display("FAIL done_in_cnt: got %0d expected 6", in_cnt);
    end
  endtask

  task automatic test_resp_bound();
    depth = 16'd3;
    do_reset();
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h42;
    bus.orig_mark = 1'b1;
    tick();
    bus.orig_mark = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      bus.in_data = 16'(i);
      tick();
      checks++;
      if (resp_timeout !== (i >= 12)) begin
        errors++;
        $display("FAIL resp_timeout beat=%0d: got %b expected %b", i, resp_timeout, (i >= 12));
      end
    end
    idle_inputs();
    checks++;
    if (in_cnt !== CW'(13)) begin
      errors++;
      $display("FAIL bound_in_cnt: got %0d expected 13", in_cnt);
    end
  endtask

  task automatic test_clk_en();
    clk_en = 1'b1;
    depth  = 16'd2;
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    clk_en        = 1'b0;
    bus.orig_mark = 1'b1;
    bus.out_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({in_cnt, out_cnt, orig_issued} !== {CW'(3), CW'(0), 1'b0}) begin
        errors++;
        $display("FAIL gated cyc=%0d: got in=%0d out=%0d oi=%b expected in=3 out=0 oi=0",
                 i, in_cnt, out_cnt, orig_issued);
      end
    end
    clk_en        = 1'b1;
    bus.orig_mark = 1'b0;
    bus.out_valid = 1'b0;
    for (int i = 0; i < 2; i++) tick();
    idle_inputs();
    checks++;
    if (in_cnt !== CW'(5)) begin
      errors++;
      $display("FAIL resumed_in_cnt: got %0d expected 5", in_cnt);
    end
  endtask

  task automatic test_reset_mid();
    depth = 16'd2;
    do_reset();
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h21;
    bus.orig_mark = 1'b1;
    tick();
    bus.orig_mark = 1'b0;
    bus.dup_mark  = 1'b1;
    bus.out_valid = 1'b1;
    bus.out_data  = 16'h21;
    tick();
    checks++;
    if ({orig_issued, dup_issued} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_issued: got %b expected 11", {orig_issued, dup_issued});
    end
    reset         = 1'b1;
    bus.orig_mark = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    check_all_zero("reset_mid");
    stim = '{16'h30, 16'h31, 16'h32, 16'h31};
    run_stream("after_reset", 1, 3, 2, -1, 16'h0, 1'b1);
  endtask

  initial begin
    reset  = 1'b0;
    clk_en = 1'b0;
    depth  = '0;
    idle_inputs();
    test_reset();
    test_match();
    test_corrupt();
    test_dup_mismatch();
    test_same_cycle();
    test_resp_bound();
    test_clk_en();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
